uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter byte path between `NREQ` byte requesters, such as a command responder and a debug/status streamer.
- Each requester presents a byte with a valid/ready handshake.
- The arbiter grants one requester, latches its byte and issues a one-cycle `tx_start_o` pulse to the transmitter input register.
- It holds ownership until the transmitter reports `tx_done_i`.
- It sits between the requesting logic and the UART transmitter, and is the only block that drives the transmitter's start and data inputs.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter byte path between NREQ requesters
//
// Grants one requester at a time, latches its byte, pulses tx_start_o once and
// holds ownership until the transmitter reports tx_done_i.
// Build option: define UART_TX_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, the lowest-index valid requester always wins.

module uart_tx_arbiter #(
  parameter int NREQ = 2,
  parameter int OWW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  output logic [OWW-1:0]    owner_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             tx_start_q;
  logic             busy_q;
  logic [7:0]       data_q;
  logic [OWW-1:0]   owner_q;

  logic [OWW-1:0]   base_ptr;
  logic             grant_any;
  logic [OWW-1:0]   grant_idx;
  logic [7:0]       grant_byte;
  logic             grant_ok;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic [OWW-1:0]   ptr_q;
  logic [OWW-1:0]   ptr_d;

  // Next search start is the requester after the one that just finished.
  always_comb begin
    ptr_d = (owner_q == OWW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  end

  assign base_ptr = ptr_q;
`else
  assign base_ptr = '0;
`endif

  // Winner search: scanning offsets from highest to lowest lets the smallest
  // offset from the search start overwrite any later candidate.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_byte = 8'h00;
    for (int i = NREQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req_valid_i[j] && (((int'(base_ptr) + i) % NREQ) == j)) begin
          grant_any = 1'b1;
          grant_idx = OWW'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == OWW'(j)) begin
        grant_byte = req_data_i[8*j +: 8];
      end
    end
  end

  // A handshake only happens from IDLE with the transmitter free and reset released.
  assign grant_ok = rstb_i && (state_q == IDLE) && !tx_busy_i && grant_any;

  // One-hot ready at the winner; zero whenever no grant is being made.
  always_comb begin
    req_ready_o = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready_o[j] = grant_ok && (grant_idx == OWW'(j));
    end
  end

  // Arbiter FSM with registered start/busy outputs and latched byte/owner.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= 8'h00;
      owner_q    <= '0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      ptr_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_start_q <= 1'b0;
          if (grant_ok) begin
            data_q     <= grant_byte;
            owner_q    <= grant_idx;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LAUNCH;
          end else begin
            busy_q     <= 1'b0;
          end
        end
        LAUNCH: begin
          // A done pulse here closes an earlier frame, so it is not looked at.
          tx_start_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tx_start_q <= 1'b0;
          if (tx_done_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign tx_data_o  = data_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table-driven bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rstb;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [0:0]  owner;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NREQ(2), .OWW(1)) dut (
    .clk_i       (clk),
    .rstb_i      (rstb),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_busy_i   (tx_busy),
    .tx_done_i   (tx_done),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .owner_o     (owner),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstb;
    logic [1:0] valid;
    logic [7:0] d1;
    logic [7:0] d0;
    logic       tbusy;
    logic       done;
    logic [1:0] e_ready;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_owner;
    logic       e_busy;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int g;
    logic rr;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    //           rstb valid  d1     d0     tbsy done | ready start data   own bsy
    vecs[0]  = '{1'b0, 2'b11, 8'h22, 8'h11, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 8'h22, 8'h11, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'b10, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 1'b1, 8'hA5, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 2'b11, 8'h22, 8'h11, 1'b1, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 8'h00, 8'h3C, 1'b0, 1'b0, 2'b01, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 2'b01, 8'h00, 8'h4D, 1'b0, 1'b0, 2'b01, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h4D, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h4D, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'b11, 8'h22, 8'h11, 1'b1, 1'b0, 2'b00, 1'b0, 8'h4D, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 2'b11, 8'h22, 8'h11, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 2'b11, 8'h22, 8'h11, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 8'h11, 1'b0, 1'b1};

    rstb      = 1'b0;
    req_valid = 2'b11;
    req_data  = 16'h2211;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      rstb      = vecs[i].rstb;
      req_valid = vecs[i].valid;
      req_data  = {vecs[i].d1, vecs[i].d0};
      tx_busy   = vecs[i].tbusy;
      tx_done   = vecs[i].done;
      @(negedge clk);
      chk("req_ready", i, 32'(req_ready), 32'(vecs[i].e_ready));
      chk("tx_start",  i, 32'(tx_start),  32'(vecs[i].e_start));
      chk("tx_data",   i, 32'(tx_data),   32'(vecs[i].e_data));
      chk("owner",     i, 32'(owner),     32'(vecs[i].e_owner));
      chk("busy",      i, 32'(busy),      32'(vecs[i].e_busy));
    end

    // Contention: both requesters valid throughout, starting from a fresh reset.
    @(posedge clk);
    #1;
    rstb      = 1'b0;
    req_valid = 2'b11;
    req_data  = 16'h2211;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = rr ? (k % 2) : 0;
      w = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (w >= 10) begin
        checks++;
        failures++;
        $display("FAIL contention_timeout grant=%0d got=no_ready expected=ready", k);
      end
      chk("cont_ready", k, 32'(req_ready), 32'(2'b01 << g));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("cont_start", k, 32'(tx_start), 32'd1);
      chk("cont_owner", k, 32'(owner), 32'(g));
      chk("cont_data",  k, 32'(tx_data), (g == 1) ? 32'h22 : 32'h11);
      @(posedge clk);
      #1;
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
